rock_driver: RTL and testbench

Downstream stage of the controller: consumes the 3-bit amplitude `A`, the 3-bit frequency `F` and the `err` flag, and turns them into a cradle swing. An internal 8-bit position oscillates around a centre point, and a PWM output drives the motor/servo. New settings are accepted only at centre crossings, so the cradle never jerks. On error the cradle returns to centre and holds.

---
 rtl/rock_pkg.sv | 28 ++
 rtl/rock_driver_if.sv | 24 ++
 rtl/rock_pwm.sv | 26 ++
 rtl/rock_driver.sv | 186 ++++++++++++++++++
 tb/tb_rock_driver.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rock_pkg.sv
// rock_pkg: shared state encoding, constants and amplitude helpers for rock_driver.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    FAULT = 2'd3
  } rock_state_t;

  localparam logic [7:0] CENTER   = 8'd128;
  localparam logic [7:0] AMP_STEP = 8'd16;
  localparam logic [2:0] F_MAX    = 3'd7;

  // Excursion limit for a latched amplitude: 0..112.
  function automatic logic [7:0] amp_limit(input logic [2:0] amp);
    return 8'(amp) * AMP_STEP;
  endfunction

  // Soft-start ramp: grow by one amplitude unit per crossing, but never
  // exceed the request; a lower request applies at once.
  function automatic logic [2:0] amp_ramp(input logic [2:0] req, input logic [2:0] cur);
    return (req > cur) ? (cur + 3'd1) : req;
  endfunction

endpackage

// File: rtl/rock_driver_if.sv
// rock_driver_if: settings in (A, F, err) and swing status/drive out of rock_driver.
// Latency: n/a (wiring only). Backpressure: none, all signals are level-sampled.
// Modports: master = controller/bench side, slave = rock_driver side.
interface rock_driver_if;
  logic [2:0] A;
  logic [2:0] F;
  logic       err;
  logic       pwm;
  logic       dir;
  logic [7:0] pos;
  logic       at_center;
  logic [1:0] state;
  logic [7:0] swings;

  modport master (
    output A, F, err,
    input  pwm, dir, pos, at_center, state, swings
  );

  modport slave (
    input  A, F, err,
    output pwm, dir, pos, at_center, state, swings
  );
endinterface

// File: rtl/rock_pwm.sv
// rock_pwm: 8-bit free-running counter compared against pos to form the motor PWM.
// Latency: o_pwm is registered, one clock behind i_pos; period 256 clocks.
// Backpressure: none. Ports: clk, reset (sync, active high), i_pos, o_pwm.
module rock_pwm (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_pos,
  output logic       o_pwm
);

  logic [7:0] r_cnt;
  logic       r_pwm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
      r_pwm <= (r_cnt < i_pos);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/rock_driver.sv
// rock_driver: cradle swing generator; oscillates pos around 128, relatches A/F only at centre crossings.
// Latency: all outputs registered; step every CLK_DIV*(8-F_l) clocks (CLK_DIV in FAULT).
// Backpressure: none. Ports: clk, reset (sync, active high), bus (rock_driver_if.slave). Option: ROCK_SOFTSTART_EN.
module rock_driver
  import rock_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  rock_driver_if.slave bus
);

  localparam int unsigned      PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  rock_state_t      r_state;
  logic [7:0]       r_pos;
  logic [2:0]       r_a_l;
  logic [2:0]       r_f_l;
  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_tick;
  logic [7:0]       r_swings;
  logic             r_dir;
  logic             r_at_center;

  rock_state_t      w_state_nx;
  logic [7:0]       w_pos_nx;
  logic [2:0]       w_a_nx;
  logic [2:0]       w_f_nx;
  logic [7:0]       w_swings_nx;
  logic             w_tick;
  logic             w_step;
  logic             w_cross;
  logic [7:0]       w_lim;
  logic [7:0]       w_pos_up;
  logic [7:0]       w_pos_dn;
  logic [2:0]       w_a_start;
  logic [2:0]       w_a_cross;
  logic             w_pwm;

  // Step generator: prescaler wrap = tick; tick-counter wrap = step.
  // In FAULT every tick is a step so the return to centre is fast.
  always_comb begin
    w_tick   = (r_pre == PRE_LAST);
    w_step   = w_tick && ((r_state == FAULT) || (r_tick == (F_MAX - r_f_l)));
    w_lim    = amp_limit(r_a_l);
    w_pos_up = r_pos + 8'd1;
    w_pos_dn = r_pos - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state == IDLE)) begin
      r_pre  <= '0;
      r_tick <= 3'd0;
    end else begin
      r_pre <= w_tick ? '0 : (r_pre + PRE_W'(1));
      if (r_state == FAULT) begin
        r_tick <= 3'd0;
      end else if (w_tick) begin
        r_tick <= (r_tick == (F_MAX - r_f_l)) ? 3'd0 : (r_tick + 3'd1);
      end
    end
  end

  // Amplitude to latch when leaving IDLE and at each centre crossing.
  always_comb begin
`ifdef ROCK_SOFTSTART_EN
    w_a_start = (bus.A != 3'd0) ? 3'd1 : 3'd0;
    w_a_cross = amp_ramp(bus.A, r_a_l);
`else
    w_a_start = bus.A;
    w_a_cross = bus.A;
`endif
  end

  always_comb begin
    w_state_nx  = r_state;
    w_pos_nx    = r_pos;
    w_a_nx      = r_a_l;
    w_f_nx      = r_f_l;
    w_swings_nx = r_swings;
    w_cross     = 1'b0;

    case (r_state)
      IDLE: begin
        w_pos_nx = CENTER;
        if ((bus.A != 3'd0) && (bus.F != 3'd0)) begin
          w_a_nx     = w_a_start;
          w_f_nx     = bus.F;
          w_state_nx = UP;
        end
      end
      UP: begin
        if (w_step) begin
          w_pos_nx = w_pos_up;
          if (w_pos_up == (CENTER + w_lim)) begin
            w_state_nx = DOWN;
          end else if (w_pos_up == CENTER) begin
            w_cross = 1'b1;
          end
        end
      end
      DOWN: begin
        if (w_step) begin
          w_pos_nx = w_pos_dn;
          if (w_pos_dn == (CENTER - w_lim)) begin
            w_state_nx  = UP;
            w_swings_nx = r_swings + 8'd1;
          end else if (w_pos_dn == CENTER) begin
            w_cross = 1'b1;
          end
        end
      end
      FAULT: begin
        if (w_step && (r_pos > CENTER)) begin
          w_pos_nx = w_pos_dn;
        end else if (w_step && (r_pos < CENTER)) begin
          w_pos_nx = w_pos_up;
        end
        if (!bus.err && (r_pos == CENTER)) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
      end
    endcase

    // Centre crossing is the only point where a moving cradle picks up new
    // settings; L >= 16 while moving, so it never coincides with a bound hit.
    if (w_cross) begin
      w_a_nx = w_a_cross;
      w_f_nx = bus.F;
      if ((w_a_cross == 3'd0) || (bus.F == 3'd0)) begin
        w_state_nx = IDLE;
      end
    end

    // err overrides everything; pos freezes on the entry edge and only the
    // FAULT stepping above may move it afterwards.
    if (bus.err) begin
      w_state_nx  = FAULT;
      w_a_nx      = r_a_l;
      w_f_nx      = r_f_l;
      w_swings_nx = r_swings;
      if (r_state != FAULT) begin
        w_pos_nx = r_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pos       <= CENTER;
      r_a_l       <= 3'd0;
      r_f_l       <= 3'd0;
      r_swings    <= 8'd0;
      r_dir       <= 1'b0;
      r_at_center <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_pos       <= w_pos_nx;
      r_a_l       <= w_a_nx;
      r_f_l       <= w_f_nx;
      r_swings    <= w_swings_nx;
      r_dir       <= (w_state_nx == UP);
      r_at_center <= (w_pos_nx == CENTER);
    end
  end

  rock_pwm u_pwm (
    .clk   (clk),
    .reset (reset),
    .i_pos (r_pos),
    .o_pwm (w_pwm)
  );

  assign bus.pwm       = w_pwm;
  assign bus.dir       = r_dir;
  assign bus.pos       = r_pos;
  assign bus.at_center = r_at_center;
  assign bus.state     = r_state;
  assign bus.swings    = r_swings;

endmodule

// File: tb/tb_rock_driver.sv
// tb_rock_driver: self-checking bench for rock_driver with CLK_DIV=4.
// Turnaround positions are checked through an expected-value queue; pwm is
// checked every cycle against a small counter/comparator model.
module tb_rock_driver;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rock_driver_if bus();

  rock_driver #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic clks(input int n);
    repeat (n) step_clk();
  endtask

  // Turnaround scoreboard: expected peak/trough positions in order.
  logic [7:0] exp_q[$];
  bit         sb_on    = 1'b0;
  logic [1:0] mon_prev = 2'd0;

  always @(negedge clk) begin
    if (reset) begin
      mon_prev <= 2'd0;
    end else begin
      if (sb_on && (((mon_prev == 2'd1) && (bus.state == 2'd2)) ||
                    ((mon_prev == 2'd2) && (bus.state == 2'd1)))) begin
        if (exp_q.size() > 0) chk("turn_pos", int'(bus.pos), int'(exp_q.pop_front()));
        else chk("turn_extra", int'(bus.pos), -1);
      end
      mon_prev <= bus.state;
    end
  end

  // PWM reference: counter from reset, output = registered (cnt < pos).
  logic [7:0] m_cnt   = 8'd0;
  logic       m_pwm   = 1'b0;
  int         pwm_bad = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 8'd0;
      m_pwm <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 8'd1;
      m_pwm <= (m_cnt < bus.pos);
    end
  end

  always @(negedge clk) begin
    if (bus.pwm !== m_pwm) pwm_bad <= pwm_bad + 1;
  end

  task automatic drain(input string name, input int budget);
    int i = 0;
    while ((exp_q.size() != 0) && (i < budget)) begin
      step_clk();
      i++;
    end
    chk(name, exp_q.size(), 0);
    sb_on = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_sp(input logic [1:0] s, input logic [7:0] p, input int budget, input string name);
    int i = 0;
    while (!((bus.state == s) && (bus.pos == p)) && (i < budget)) begin
      step_clk();
      i++;
    end
    chk(name, int'((bus.state == s) && (bus.pos == p)), 1);
  endtask

  typedef struct {
    logic [2:0] a;
    logic [2:0] f;
    int         step;
    logic [7:0] peak;
    logic [7:0] trough;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int hi;
    int mono;
    logic [7:0] prev;

    vecs[0] = '{3'd1, 3'd7, 4,  8'd144, 8'd112};
    vecs[1] = '{3'd2, 3'd6, 8,  8'd160, 8'd96};
    vecs[2] = '{3'd3, 3'd5, 12, 8'd176, 8'd80};
    vecs[3] = '{3'd1, 3'd1, 28, 8'd144, 8'd112};
`ifdef ROCK_SOFTSTART_EN
    vecs[4] = '{3'd7, 3'd7, 4,  8'd144, 8'd96};
`else
    vecs[4] = '{3'd7, 3'd7, 4,  8'd240, 8'd16};
`endif

    // Reset with settings already applied.
    bus.A = 3'd3; bus.F = 3'd5; bus.err = 1'b0; reset = 1'b1;
    clks(3);
    chk("rst_pos",    int'(bus.pos), 128);
    chk("rst_state",  int'(bus.state), 0);
    chk("rst_pwm",    int'(bus.pwm), 0);
    chk("rst_center", int'(bus.at_center), 1);
    chk("rst_swings", int'(bus.swings), 0);
    chk("rst_dir",    int'(bus.dir), 0);
    reset = 1'b0;
    step_clk();
    chk("rel_state", int'(bus.state), 1);
    chk("rel_dir",   int'(bus.dir), 1);
    chk("rel_pos",   int'(bus.pos), 128);

    // Table: step interval, first step, peak, trough and swing count.
    foreach (vecs[k]) begin
      reset = 1'b1; bus.A = vecs[k].a; bus.F = vecs[k].f;
      clks(2);
      reset = 1'b0;
      step_clk();
      chk($sformatf("v%0d_up", k), int'(bus.state), 1);
      n = 0;
      while ((bus.pos == 8'd128) && (n < 400)) begin
        step_clk();
        n++;
      end
      chk($sformatf("v%0d_step_clks", k), n, vecs[k].step);
      chk($sformatf("v%0d_first_pos", k), int'(bus.pos), 129);
      chk($sformatf("v%0d_off_center", k), int'(bus.at_center), 0);
      exp_q.push_back(vecs[k].peak);
      exp_q.push_back(vecs[k].trough);
      sb_on = 1'b1;
      drain($sformatf("v%0d_turns", k), 6000);
      chk($sformatf("v%0d_swings", k), int'(bus.swings), 1);
    end

    // Amplitude change mid-rise takes effect only at the next crossing.
    reset = 1'b1; bus.A = 3'd1; bus.F = 3'd7;
    clks(2);
    reset = 1'b0;
    wait_sp(2'd1, 8'd140, 400, "achg_reach_140");
    bus.A = 3'd3;
    exp_q.push_back(8'd144);
    exp_q.push_back(8'd80);
    exp_q.push_back(8'd176);
    sb_on = 1'b1;
    drain("achg_turns", 4000);
    chk("achg_swings", int'(bus.swings), 1);

    // F dropped to 0 while falling: continue to centre, then IDLE and hold.
    wait_sp(2'd2, 8'd135, 400, "f0_reach_135");
    bus.F = 3'd0;
    n = 0;
    prev = bus.pos;
    while ((bus.state != 2'd0) && (n < 200)) begin
      prev = bus.pos;
      step_clk();
      n++;
    end
    chk("f0_state",  int'(bus.state), 0);
    chk("f0_prev",   int'(prev), 129);
    chk("f0_pos",    int'(bus.pos), 128);
    chk("f0_center", int'(bus.at_center), 1);
    clks(40);
    chk("f0_hold_pos",   int'(bus.pos), 128);
    chk("f0_hold_state", int'(bus.state), 0);

    // PWM duty at centre over one full period.
    hi = 0;
    repeat (256) begin
      step_clk();
      if (bus.pwm) hi++;
    end
    chk("pwm_duty_128", hi, 128);

    // err pulse at pos=150 while rising.
    reset = 1'b1; bus.A = 3'd2; bus.F = 3'd7;
    clks(2);
    reset = 1'b0;
    wait_sp(2'd1, 8'd150, 400, "err_reach_150");
    bus.err = 1'b1;
    step_clk();
    chk("err_state", int'(bus.state), 3);
    chk("err_pos",   int'(bus.pos), 150);
    chk("err_dir",   int'(bus.dir), 0);
    bus.err = 1'b0;
    n = 1;
    mono = 1;
    while ((bus.pos != 8'd128) && (n < 300)) begin
      prev = bus.pos;
      step_clk();
      n++;
      if ((bus.pos != prev) && (bus.pos != (prev - 8'd1))) mono = 0;
    end
    chk("fault_clks_to_center", n, 88);
    chk("fault_monotonic", mono, 1);
    chk("fault_still", int'(bus.state), 3);
    step_clk();
    chk("fault_to_idle", int'(bus.state), 0);
    chk("fault_idle_pos", int'(bus.pos), 128);
    step_clk();
    chk("fault_idle_to_up", int'(bus.state), 1);

    // Full amplitude from IDLE.
    reset = 1'b1; bus.A = 3'd7; bus.F = 3'd7;
    clks(2);
    reset = 1'b0;
`ifdef ROCK_SOFTSTART_EN
    exp_q.push_back(8'd144); exp_q.push_back(8'd96);
    exp_q.push_back(8'd176); exp_q.push_back(8'd64);
    exp_q.push_back(8'd208); exp_q.push_back(8'd32);
    exp_q.push_back(8'd240); exp_q.push_back(8'd16);
`else
    exp_q.push_back(8'd240); exp_q.push_back(8'd16);
    exp_q.push_back(8'd240);
`endif
    sb_on = 1'b1;
    drain("full_amp_turns", 8000);

    // Reset mid-swing: straight back to reset values.
    clks(37);
    reset = 1'b1;
    step_clk();
    chk("midrst_pos",    int'(bus.pos), 128);
    chk("midrst_state",  int'(bus.state), 0);
    chk("midrst_swings", int'(bus.swings), 0);
    chk("midrst_dir",    int'(bus.dir), 0);
    chk("midrst_center", int'(bus.at_center), 1);

    // err in IDLE beats the IDLE->UP transition.
    reset = 1'b0;
    bus.err = 1'b1;
    step_clk();
    chk("idle_err_fault", int'(bus.state), 3);
    bus.err = 1'b0;
    step_clk();
    chk("idle_err_release", int'(bus.state), 0);
    step_clk();
    chk("idle_err_resume", int'(bus.state), 1);

    step_clk();
    chk("pwm_model", pwm_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
